// File: rtl/tilelink_ram_responder.sv
// TileLink-UL responder terminating the pinwheel_core A channel onto a byte-maskable word RAM.
// Optional tag/opcode error responses are enabled by defining TILELINK_RAM_ERROR_EN.
package tilelink_ram_pkg;

   typedef struct packed {
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [2:0]  a_size;
      logic [3:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        a_valid;
      logic        a_ready;
   } tilelink_a;

   typedef struct packed {
      logic [2:0]  d_opcode;
      logic [1:0]  d_param;
      logic [2:0]  d_size;
      logic [3:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        d_valid;
      logic        d_ready;
   } tilelink_d;

   localparam logic [2:0] TL_PUT_FULL        = 3'd0;
   localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
   localparam logic [2:0] TL_GET             = 3'd4;
   localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
   localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

endpackage

module tilelink_ram_responder
   import tilelink_ram_pkg::*;
#(
   parameter int         WORDS       = 1024,
   parameter logic [3:0] BASE_TAG    = 4'h8,
   parameter int         WAIT_CYCLES = 0
) (
   input  logic      clock,
   input  logic      tick_reset_in,
   input  tilelink_a tock_tla,
   output tilelink_d tld
);

   localparam int         AW        = $clog2(WORDS);
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t      r_state;
   state_t      w_stateNext;
   logic [3:0]  r_count;
   logic [3:0]  w_countNext;

   logic [2:0]  r_dOpcode;
   logic [31:0] r_dData;
   logic        r_dError;
   logic [2:0]  r_dSize;
   logic [3:0]  r_dSource;

   logic [31:0] r_mem [WORDS];

   logic          w_aReady;
   logic          w_accept;
   logic          w_isPut;
   logic          w_isGet;
   logic          w_err;
   logic          w_write;
   logic [AW-1:0] w_index;
   logic          w_unused;

   assign w_aReady = (r_state == IDLE) || ((r_state == RESP) && tock_tla.a_ready);
   assign w_accept = tock_tla.a_valid && w_aReady;
   assign w_isPut  = (tock_tla.a_opcode == TL_PUT_FULL) || (tock_tla.a_opcode == TL_PUT_PARTIAL);
   assign w_isGet  = (tock_tla.a_opcode == TL_GET);
   assign w_index  = tock_tla.a_address[AW+1:2];

`ifdef TILELINK_RAM_ERROR_EN
   assign w_err = (tock_tla.a_address[31:28] != BASE_TAG) || !(w_isPut || w_isGet);
`else
   assign w_err = 1'b0;
`endif

   // Reset takes priority so an accept coinciding with reset never touches the RAM.
   assign w_write  = w_accept && w_isPut && !w_err && !tick_reset_in;
   assign w_unused = ^{tock_tla.a_param, tock_tla.a_address, w_isGet, BASE_TAG};

   always_ff @(posedge clock) begin
      if (tick_reset_in) begin
         r_state <= IDLE;
         r_count <= 4'd0;
      end else begin
         r_state <= w_stateNext;
         r_count <= w_countNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      w_countNext = r_count;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (WAIT_CYCLES > 0) begin
                  w_stateNext = WAIT;
                  w_countNext = WAIT_LOAD;
               end else begin
                  w_stateNext = RESP;
               end
            end
         end
         WAIT: begin
            if (r_count == 4'd0) begin
               w_stateNext = RESP;
            end else begin
               w_countNext = r_count - 4'd1;
            end
         end
         RESP: begin
            if (tock_tla.a_ready) begin
               if (w_accept) begin
                  if (WAIT_CYCLES > 0) begin
                     w_stateNext = WAIT;
                     w_countNext = WAIT_LOAD;
                  end else begin
                     w_stateNext = RESP;
                  end
               end else begin
                  w_stateNext = IDLE;
               end
            end
         end
         default: begin
            w_stateNext = IDLE;
            w_countNext = 4'd0;
         end
      endcase
   end

   // Response fields only change on an accept, which keeps them stable for the whole beat.
   always_ff @(posedge clock) begin
      if (tick_reset_in) begin
         r_dOpcode <= TL_ACCESS_ACK;
         r_dData   <= 32'd0;
         r_dError  <= 1'b0;
         r_dSize   <= 3'd0;
         r_dSource <= 4'd0;
      end else if (w_accept) begin
         r_dOpcode <= w_isPut ? TL_ACCESS_ACK : TL_ACCESS_ACK_DATA;
         r_dData   <= (w_isPut || w_err) ? 32'd0 : r_mem[w_index];
         r_dError  <= w_err;
         r_dSize   <= tock_tla.a_size;
         r_dSource <= tock_tla.a_source;
      end
   end

   always_ff @(posedge clock) begin
      if (w_write) begin
         for (int b = 0; b < 4; b++) begin
            if (tock_tla.a_mask[b]) begin
               r_mem[w_index][8*b +: 8] <= tock_tla.a_data[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      tld          = '0;
      tld.d_opcode = r_dOpcode;
      tld.d_param  = 2'd0;
      tld.d_size   = r_dSize;
      tld.d_source = r_dSource;
      tld.d_sink   = 1'b0;
      tld.d_data   = r_dData;
      tld.d_error  = r_dError;
      tld.d_valid  = (r_state == RESP);
      tld.d_ready  = w_aReady;
   end

endmodule
